// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: FIFO-fed framer with word length, parity, stop and break control.
// Frame settings are latched at pop, so LCR writes only take effect from the next word.
module uart_tx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       tx_fifo_empty_i,
  input  logic [7:0] tx_fifo_in,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       set_break,
  output logic       tx_pop_o,
  output logic       tx_o,
  output logic       temt_o,
  output logic       busy_o
);

  localparam int TW = $clog2(2 * OVS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      wls_q, wls_d;
  logic            stb_q, stb_d;
  logic            pen_q, pen_d;
  logic            eps_q, eps_d;
  logic            stk_q, stk_d;
  logic            tx_q, tx_d;

  logic            load;
  logic            last_data;
  logic [TW-1:0]   bit_len_m1;
  logic [7:0]      data_mask;
  logic            par_bit;
  logic            line;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    data_d     = data_q;
    wls_d      = wls_q;
    stb_d      = stb_q;
    pen_d      = pen_q;
    eps_d      = eps_q;
    stk_d      = stk_q;
    load       = 1'b0;
    line       = 1'b1;
    last_data  = (bit_q == (3'd4 + {1'b0, wls_q}));

    // Only STOP stretches; 1.5 stop bits applies to 5-bit words.
    bit_len_m1 = TW'(OVS - 1);
    if (state_q == STOP && stb_q) begin
      bit_len_m1 = (wls_q == 2'b00) ? TW'(3 * OVS / 2 - 1) : TW'(2 * OVS - 1);
    end

    case (state_q)
      IDLE: begin
        if (!tx_fifo_empty_i) load = 1'b1;
      end
      default: begin
        if (baud_pulse) begin
          if (tick_q == bit_len_m1) begin
            tick_d = '0;
            case (state_q)
              START: begin
                state_d = DATA;
                bit_d   = 3'd0;
              end
              DATA: begin
                if (last_data) state_d = pen_q ? PARITY : STOP;
                else           bit_d   = bit_q + 3'd1;
              end
              PARITY: state_d = STOP;
              STOP: begin
                if (!tx_fifo_empty_i) load    = 1'b1;
                else                  state_d = IDLE;
              end
              default: state_d = IDLE;
            endcase
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
    endcase

    if (load) begin
      data_d  = tx_fifo_in;
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      eps_d   = eps;
      stk_d   = sticky_parity;
      state_d = START;
      tick_d  = '0;
      bit_d   = 3'd0;
    end

    // Line value is derived from the next state so tx_o is a clean register.
    data_mask = 8'hFF >> (2'd3 - wls_d);
    par_bit   = stk_d ? ~eps_d : (eps_d ? ^(data_d & data_mask) : ~^(data_d & data_mask));
    case (state_d)
      START:   line = 1'b0;
      DATA:    line = data_d[bit_d];
      PARITY:  line = par_bit;
      default: line = 1'b1;
    endcase
    tx_d = set_break ? 1'b0 : line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      wls_q   <= 2'b00;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      stk_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      stk_q   <= stk_d;
      tx_q    <= tx_d;
    end
  end

  // Pop must coincide with the capture edge because the FIFO is fall-through.
  assign tx_pop_o = load & ~rst;
  assign tx_o     = tx_q;
  assign busy_o   = (state_q != IDLE);
  assign temt_o   = (state_q == IDLE) & tx_fifo_empty_i;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed table-driven bench for uart_tx.
module tb_uart_tx;
  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst, baud_pulse, tx_fifo_empty_i;
  logic [7:0] tx_fifo_in;
  logic [1:0] wls;
  logic       stb, pen, eps, sticky_parity, set_break;
  logic       tx_pop_o, tx_o, temt_o, busy_o;

  uart_tx #(.OVS(OVS)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .tx_fifo_empty_i(tx_fifo_empty_i),
    .tx_fifo_in(tx_fifo_in), .wls(wls), .stb(stb), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .set_break(set_break), .tx_pop_o(tx_pop_o),
    .tx_o(tx_o), .temt_o(temt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  wls;
    logic        stb, pen, eps, stk;
    int          div;
    logic [11:0] bits;
    int          nbits;
    int          stop_ticks;
  } vec_t;

  vec_t       vt[7];
  logic [7:0] fifo[$];
  int         pop_log[$];
  logic       exp_q[$];
  logic       wave[$];
  int         n_cmp = 0, n_bad = 0, cyc_n = 0, bcnt = 0, div = 1;
  int         p, pops0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic upd();
    tx_fifo_empty_i = (fifo.size() == 0);
    tx_fifo_in      = (fifo.size() == 0) ? 8'h00 : fifo[0];
    #1;
  endtask

  task automatic cyc();
    logic pn;
    pn = tx_pop_o;
    if (pn) begin
      pop_log.push_back(cyc_n);
      if (fifo.size() > 0) fifo.delete(0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bcnt       = pn ? 0 : bcnt + 1;
    baud_pulse = ((bcnt % div) == div - 1);
    upd();
  endtask

  task automatic add_frame(input logic [11:0] bits, input int n, input int stop_ticks, input int d);
    repeat (OVS * d) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) repeat (OVS * d) exp_q.push_back(bits[i]);
    repeat (stop_ticks * d) exp_q.push_back(1'b1);
  endtask

  task automatic wait_pop(input string name, output int pc);
    int t = 0;
    while (!tx_pop_o && t < 20) begin
      cyc();
      t++;
    end
    chk({name, "_pop_seen"}, tx_pop_o, 1);
    pc = cyc_n;
  endtask

  task automatic record(input int brk_at, input int brk_len, input bit mess);
    wave.delete();
    for (int k = 1; k <= exp_q.size(); k++) begin
      cyc();
      wave.push_back(tx_o);
      if (brk_at > 0 && k == brk_at) set_break = 1'b1;
      if (brk_at > 0 && k == brk_at + brk_len) set_break = 1'b0;
      if (mess && k == 5) begin
        wls = ~wls; stb = ~stb; pen = ~pen; eps = ~eps; sticky_parity = ~sticky_parity;
      end
    end
  endtask

  task automatic cmp_wave(input string name);
    int bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (wave[i] !== exp_q[i]) bad++;
    chk({name, "_wave_bad_cycles"}, bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          data   wls    stb   pen   eps   stk   div bits    n  stop
    vt[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 12'h0A5, 8, 16};
    vt[1] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1, 12'h003, 8, 16};
    vt[2] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1, 12'h083, 8, 16};
    vt[3] = '{8'hF6, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4, 12'h016, 5, 24};
    vt[4] = '{8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1, 12'h007, 9, 32};
    vt[5] = '{8'h41, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1, 12'h041, 7, 16};
    vt[6] = '{8'h01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1, 12'h001, 9, 16};

    rst = 1'b1; baud_pulse = 1'b1; set_break = 1'b0;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    upd();
    repeat (3) cyc();
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pop", tx_pop_o, 0);
    chk("rst_temt", temt_o, 1);
    fifo.push_back(8'h5A);
    upd();
    chk("rst_pop_blocked", tx_pop_o, 0);
    chk("rst_temt_follows_fifo", temt_o, 0);
    fifo.delete();
    upd();
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      wls = vt[i].wls; stb = vt[i].stb; pen = vt[i].pen; eps = vt[i].eps;
      sticky_parity = vt[i].stk; div = vt[i].div;
      pops0 = pop_log.size();
      fifo.push_back(vt[i].data);
      upd();
      wait_pop(nm, p);
      exp_q.delete();
      add_frame(vt[i].bits, vt[i].nbits, vt[i].stop_ticks, vt[i].div);
      record(0, 0, 1'b1);
      cmp_wave(nm);
      chk({nm, "_busy_last"}, busy_o, 1);
      cyc();
      chk({nm, "_busy_after"}, busy_o, 0);
      chk({nm, "_temt_after"}, temt_o, 1);
      chk({nm, "_tx_idle"}, tx_o, 1);
      chk({nm, "_pops"}, pop_log.size() - pops0, 1);
      repeat (3) cyc();
    end

    // back-to-back frames, second pop on the final STOP cycle
    wls = 2'b11; stb = 1'b0; pen = 1'b0; div = 1;
    pops0 = pop_log.size();
    fifo.push_back(8'h55);
    fifo.push_back(8'hAA);
    upd();
    wait_pop("b2b", p);
    exp_q.delete();
    add_frame(12'h055, 8, 16, 1);
    add_frame(12'h0AA, 8, 16, 1);
    record(0, 0, 1'b0);
    cmp_wave("b2b");
    if (pop_log.size() >= pops0 + 2) chk("b2b_second_pop_offset", pop_log[pops0 + 1] - p, 160);
    else chk("b2b_second_pop_present", pop_log.size() - pops0, 2);
    repeat (20) cyc();
    chk("b2b_total_pops", pop_log.size() - pops0, 2);
    chk("b2b_temt", temt_o, 1);

    // break in the middle of DATA, frame timing unchanged
    fifo.push_back(8'hA5);
    upd();
    wait_pop("brk", p);
    exp_q.delete();
    add_frame(12'h0A5, 8, 16, 1);
    for (int i = 40; i < 90; i++) exp_q[i] = 1'b0;
    record(40, 50, 1'b0);
    cmp_wave("brk");
    chk("brk_busy_last", busy_o, 1);
    cyc();
    chk("brk_busy_after", busy_o, 0);
    repeat (3) cyc();

    // reset during DATA aborts the frame
    fifo.push_back(8'hA5);
    upd();
    wait_pop("rstmid", p);
    repeat (30) cyc();
    chk("rstmid_busy_before", busy_o, 1);
    rst = 1'b1;
    cyc();
    chk("rstmid_tx", tx_o, 1);
    chk("rstmid_busy", busy_o, 0);
    rst = 1'b0;
    pops0 = pop_log.size();
    repeat (20) cyc();
    chk("rstmid_no_repop", pop_log.size() - pops0, 0);
    chk("rstmid_temt", temt_o, 1);
    chk("rstmid_tx_idle", tx_o, 1);

    // first pop allowed on the first cycle out of reset
    rst = 1'b1;
    cyc();
    fifo.push_back(8'h3C);
    upd();
    chk("rel_pop_in_rst", tx_pop_o, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rel_first_pop", tx_pop_o, 1);
    pops0 = pop_log.size();
    repeat (200) cyc();
    chk("rel_pops", pop_log.size() - pops0, 1);
    chk("rel_temt", temt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
